// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: frames UART bytes into register-write/arm/abort strobes; define CMD_CHECKSUM_EN to add a checksum byte
module uart_cmd_decoder #(
  parameter int INPUT_CLK_KHZ = 100_000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic        input_clk,
  input  logic        reset,
  input  logic [7:0]  data_received,
  input  logic        data_rdy,
  output logic        reg_wr,
  output logic [3:0]  reg_addr,
  output logic [15:0] reg_data,
  output logic        arm_pulse,
  output logic        abort_pulse,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);
  localparam logic [31:0] TIMEOUT_CYC = 32'(INPUT_CLK_KHZ * TIMEOUT_MS);
`ifdef CMD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CSUM, EXEC} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, EXEC} state_t;
`endif
  state_t state, state_d;
  logic s1, s2, s3, strobe, tmo, csum_bad;
  logic [31:0] cnt;
  logic [7:0] cmd, dhi, dlo;
  logic wr_d, arm_d, abort_d, err_d;
  logic [1:0] code_d;
  assign strobe = s2 & ~s3;
  assign busy = state != IDLE;
  assign tmo = state != IDLE && state != EXEC && !strobe && cnt == TIMEOUT_CYC - 32'd1;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] csum;
  assign csum_bad = csum != (cmd ^ dhi ^ dlo);
`else
  assign csum_bad = 1'b0;
`endif
  // synchronize data_rdy and time the gap since the last accepted byte
  always_ff @(posedge input_clk or negedge reset)
    if (!reset) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
    end else begin
      {s1, s2, s3} <= {data_rdy, s1, s2};
      cnt <= (strobe || state == IDLE) ? '0 : cnt + 32'd1;
    end
  // state register, frame byte capture and registered result strobes
  always_ff @(posedge input_clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {cmd, dhi, dlo} <= '0;
      {reg_wr, arm_pulse, abort_pulse, frame_err} <= '0;
      reg_addr <= '0;
      reg_data <= '0;
      err_code <= '0;
`ifdef CMD_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= state_d;
      if (strobe && state == CMD) cmd <= data_received;
      if (strobe && state == DHI) dhi <= data_received;
      if (strobe && state == DLO) dlo <= data_received;
`ifdef CMD_CHECKSUM_EN
      if (strobe && state == CSUM) csum <= data_received;
`endif
      {reg_wr, arm_pulse, abort_pulse, frame_err} <= {wr_d, arm_d, abort_d, err_d};
      err_code <= code_d;
      if (wr_d) begin
        reg_addr <= cmd[3:0];
        reg_data <= {dhi, dlo};
      end
    end
  // next state and the one strobe a finished (or timed-out) frame produces
  always_comb begin
    state_d = state;
    {wr_d, arm_d, abort_d, err_d} = '0;
    code_d = err_code;
    case (state)
      IDLE: state_d = (strobe && data_received == 8'hA5) ? CMD : IDLE;
      CMD:  state_d = strobe ? DHI : CMD;
      DHI:  state_d = strobe ? DLO : DHI;
`ifdef CMD_CHECKSUM_EN
      DLO:  state_d = strobe ? CSUM : DLO;
      CSUM: state_d = strobe ? EXEC : CSUM;
`else
      DLO:  state_d = strobe ? EXEC : DLO;
`endif
      EXEC: begin
        state_d = IDLE;
        if (csum_bad) {err_d, code_d} = {1'b1, 2'd3};
        else if (cmd[7:4] == 4'h8) wr_d = 1'b1;
        else if (cmd == 8'h01) arm_d = 1'b1;
        else if (cmd == 8'h02) abort_d = 1'b1;
        else {err_d, code_d} = {1'b1, 2'd1};
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = IDLE;
      {err_d, code_d} = {1'b1, 2'd2};
    end
  end
endmodule
